cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss handler between the L1 caches and the multi-cycle main memory (single-cycle write, 4-cycle pipelined read, data_valid strobe, pipeline flushed whenever enable drops).
- On a miss, streams the 8 words of a 16-byte block from memory and writes each into the cache data array, then updates the tag.
- Also forwards single-word write-through stores to memory.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2).
- MEM_LATENCY, 4, memory read latency in cycles, used for checking and assertions only.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- miss_req  in  1  cache miss; sampled only in IDLE
- miss_addr  in  ADDR_WIDTH  byte address of the missing access
- st_req  in  1  write-through store request; sampled only in IDLE
- st_addr  in  ADDR_WIDTH  store byte address (bit 0 = 0)
- st_data  in  16  store data
- st_ack  out  1  one-cycle pulse: store issued this cycle
- busy  out  1  high while a fill is in progress
- fill_we  out  1  write-enable for the cache data array
- fill_word  out  3  word index within the block for fill_data
- fill_data  out  16  word returned by memory
- tag_we  out  1  one-cycle pulse: write tag/valid for the filled block
- fill_done  out  1  one-cycle pulse, coincident with tag_we
- fill_blk  out  ADDR_WIDTH-4  captured block address (for tag write)
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_data_in  out  16  to memory data_in
- mem_data_out  in  16  from memory data_out
- mem_data_valid  in  1  from memory data_valid

Behaviour:
- Reset (rst low, async): state IDLE, issue_cnt=0, recv_cnt=0, fill_blk=0. All outputs 0.
- States: IDLE, STORE, FILL.
- IDLE:
  - mem_enable=0, busy=0.
  - If st_req: go to STORE and latch st_addr and st_data. Store has priority over miss_req in the same cycle.
  - Else if miss_req: go to FILL, latch fill_blk=miss_addr[15:4], clear both counters.
- STORE (exactly 1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr/mem_data_in = latched values, st_ack=1.
  - Next state IDLE. A miss_req held by the cache is taken on the following IDLE cycle.
- FILL:
  - busy=1, mem_enable=1, mem_wr=0 every cycle. Enable must not drop mid-fill, because that flushes the memory pipeline.
  - mem_addr = {fill_blk, issue_cnt, 1'b0}.
  - issue_cnt increments each cycle and saturates at 7. Redundant re-reads of word 7 are harmless.
  - On mem_data_valid: fill_we=1, fill_word=recv_cnt, fill_data=mem_data_out, recv_cnt++.
  - When mem_data_valid and recv_cnt==7: tag_we=1 and fill_done=1 in the same cycle, next state IDLE. mem_enable=0 the next cycle, which discards surplus in-flight reads.
- Timing, with the request sampled in cycle 0:
  - Address issue in cycles 1..8 (words 0..7).
  - Data valid in cycles 5..12.
  - fill_done in cycle 12; busy high in cycles 1..12.
  - IDLE in cycle 13, when a new request can be accepted.
- mem_data_valid in IDLE or STORE: ignored.
- miss_req and st_req while busy: ignored. The cache must hold them.
- Reset asserted mid-fill: immediate return to IDLE, no tag_we. The memory pipeline self-clears because enable is low.
- fill_word/fill_data are don't-care when fill_we=0; the RTL drives 0.
- Widths: counters are 3 bits, and the recv_cnt wrap after word 7 coincides with leaving FILL.

Decomposition:
- Shared include/package:
  - state encoding (IDLE=2'd0, STORE=2'd1, FILL=2'd2)
  - BLK_OFF_BITS=4
  - WORD_IDX_BITS=3
  - MEM_LATENCY=4
- One natural sub-module: word_counter (3-bit, sync clear, enable, optional saturate), instantiated for issue_cnt and recv_cnt.

Test Plan:
- Basic fill: miss_req with miss_addr=16'h1236, memory preloaded with words 16'hA000+i at 0x1230+2i.
  - Required: mem_addr 0x1230..0x123E in cycles 1..8.
  - Required: fill_we in cycles 5..12 with fill_word 0..7 and fill_data A000..A007.
  - Required: tag_we/fill_done in cycle 12 with fill_blk=12'h123; busy=0 in cycle 13.
- Store: st_req with st_addr=16'h0040, st_data=16'hBEEF.
  - Required: one cycle later mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_data_in=BEEF, st_ack=1.
  - Required: a subsequent fill of block 0x004 returns BEEF at fill_word 0.
- Simultaneous st_req and miss_req in IDLE:
  - Required: STORE first (st_ack pulse), then FILL starting the next IDLE cycle.
  - Required: mem_enable never drops during FILL.
- Requests while busy: st_req pulsed in cycle 6 of a fill.
  - Required: no st_ack and no mem_wr during FILL; the store is accepted after fill_done once held.
- Reset mid-fill: rst low in cycle 7.
  - Required: all outputs 0 asynchronously and no tag_we.
  - Required: after release, a new miss to 0xFFF0 completes correctly in 12 cycles.
- Back-to-back fills: miss_req held high across fill_done with a new miss_addr=0x2000.
  - Required: second fill accepted in cycle 13.
  - Required: no stale words from the first block appear on fill_data.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared state encoding and geometry constants for the fill FSM
package cache_fill_fsm_pkg;

  localparam int BLK_OFF_BITS  = 4;  // byte offset bits inside a 16-byte block
  localparam int WORD_IDX_BITS = 3;  // 16-bit word index inside a block
  localparam int MEM_LATENCY   = 4;  // memory read latency, address to data_valid

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - main memory bus between the fill FSM and the memory
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);

  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           data_in;
  logic [15:0]           data_out;
  logic                  data_valid;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid
  );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// rtl/cache_fill_fsm_word_counter.sv - 3-bit word counter with sync clear and optional saturation
module cache_fill_fsm_word_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [WORD_IDX_BITS-1:0] cnt
);

  localparam logic [WORD_IDX_BITS-1:0] TOP = '1;

  // count up on enable; a saturating counter parks at the top value instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(SATURATE && (cnt == TOP))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss handler: block fill from memory and write-through store forwarding
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = cache_fill_fsm_pkg::MEM_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  input  logic                             st_req,
  input  logic [ADDR_WIDTH-1:0]            st_addr,
  input  logic [15:0]                      st_data,
  output logic                             st_ack,
  output logic                             busy,
  output logic                             fill_we,
  output logic [WORD_IDX_BITS-1:0]         fill_word,
  output logic [15:0]                      fill_data,
  output logic                             tag_we,
  output logic                             fill_done,
  output logic [ADDR_WIDTH-BLK_OFF_BITS-1:0] fill_blk,
  cache_fill_fsm_if.master                 mem
);

  localparam logic [WORD_IDX_BITS-1:0] LAST_WORD = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

  // The word counters are fixed at 3 bits and the memory must have a real pipeline.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != (1 << WORD_IDX_BITS)) begin : g_param_check
    $error("cache_fill_fsm: unsupported MEM_LATENCY or WORDS_PER_BLOCK");
  end

  state_t                            state, state_nxt;
  logic [ADDR_WIDTH-1:0]             st_addr_q;
  logic [15:0]                       st_data_q;
  logic [ADDR_WIDTH-BLK_OFF_BITS-1:0] blk_q;
  logic [WORD_IDX_BITS-1:0]          issue_cnt, recv_cnt;
  logic                              accept_st, accept_miss;
  logic                              in_fill;

  assign in_fill  = (state == FILL);
  assign fill_blk = blk_q;

  // Issue side keeps re-reading word 7 once all addresses are out; the surplus reads are
  // discarded when enable drops after the last word arrives.
  cache_fill_fsm_word_counter #(.SATURATE(1'b1)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept_miss),
    .en  (in_fill),
    .cnt (issue_cnt)
  );

  // Receive side wraps 7->0 on the same edge that leaves FILL.
  cache_fill_fsm_word_counter #(.SATURATE(1'b0)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept_miss),
    .en  (in_fill && mem.data_valid),
    .cnt (recv_cnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture the accepted store payload and the block address of an accepted miss
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_addr_q <= '0;
      st_data_q <= '0;
      blk_q     <= '0;
    end else begin
      if (accept_st) begin
        st_addr_q <= st_addr;
        st_data_q <= st_data;
      end
      if (accept_miss) begin
        blk_q <= miss_addr[ADDR_WIDTH-1:BLK_OFF_BITS];
      end
    end
  end

  // next-state and outputs; enable stays high for the whole fill so the read pipeline is kept
  always_comb begin
    state_nxt    = state;
    accept_st    = 1'b0;
    accept_miss  = 1'b0;
    st_ack       = 1'b0;
    busy         = 1'b0;
    fill_we      = 1'b0;
    fill_word    = '0;
    fill_data    = '0;
    tag_we       = 1'b0;
    fill_done    = 1'b0;
    mem.enable   = 1'b0;
    mem.wr       = 1'b0;
    mem.addr     = '0;
    mem.data_in  = '0;
    unique case (state)
      IDLE: begin
        if (st_req) begin
          accept_st = 1'b1;
          state_nxt = STORE;
        end else if (miss_req) begin
          accept_miss = 1'b1;
          state_nxt   = FILL;
        end
      end
      STORE: begin
        mem.enable  = 1'b1;
        mem.wr      = 1'b1;
        mem.addr    = st_addr_q;
        mem.data_in = st_data_q;
        st_ack      = 1'b1;
        state_nxt   = IDLE;
      end
      FILL: begin
        busy       = 1'b1;
        mem.enable = 1'b1;
        mem.addr   = {blk_q, issue_cnt, 1'b0};
        if (mem.data_valid) begin
          fill_we   = 1'b1;
          fill_word = recv_cnt;
          fill_data = mem.data_out;
          if (recv_cnt == LAST_WORD) begin
            tag_we    = 1'b1;
            fill_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
